ras_ckpt: RTL and testbench
===========================

Name: ras_ckpt

Overview:
- Parametrised return-address stack (RAS) with speculative checkpoint/restore, for the CVA6 frontend branch predictor.
- Successor to the fixed-depth RAS: any depth of 2 or more, circular overwrite on overflow, and push+pop replace (coroutine call).
- Adds a single-level snapshot so the frontend can repair pointer, count and top entry after a mispredict.
- Sits beside the BTB/BHT; depth is set from the core configuration's RAS depth.

Parameters:
- Depth, 2, number of return-address entries; must be 2 or more; need not be a power of two.
- VLEN, 64, return-address width in bits.
- PtrW, $clog2(Depth), top-pointer width; derived, not overridable.
- CntW, $clog2(Depth+1), occupancy-count width; derived.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  empty the stack and clear the snapshot.
- push_i  in  1  push push_addr_i (call).
- pop_i  in  1  pop the top entry (return).
- push_addr_i  in  VLEN  return address to push.
- ckpt_i  in  1  capture a snapshot of the current state.
- restore_i  in  1  restore state from the snapshot.
- top_valid_o  out  1  stack is non-empty.
- top_addr_o  out  VLEN  address at the top of the stack; 0 when empty.
- count_o  out  CntW  current occupancy, 0..Depth.
- overflow_o  out  1  one-cycle pulse: a push overwrote the oldest entry.
- underflow_o  out  1  one-cycle pulse: a pop was attempted on an empty stack.

Behaviour:
- State:
  - mem[Depth] of VLEN bits.
  - tp_q, index of the top entry.
  - cnt_q, occupancy.
  - Snapshot registers snap_tp_q, snap_cnt_q, snap_top_q.
- Reset (rst_i=1, asynchronous):
  - tp_q=0, cnt_q=0, all mem entries=0, all snapshot registers=0, overflow_o=0, underflow_o=0.
  - Therefore top_valid_o=0, top_addr_o=0, count_o=0.
  - Reset asserted mid-operation discards everything immediately.
- Outputs:
  - top_valid_o = (cnt_q != 0).
  - top_addr_o = mem[tp_q] when cnt_q != 0, else 0.
  - count_o = cnt_q.
  - All three are combinational from flops; a push or pop becomes visible one cycle after the request cycle.
  - overflow_o and underflow_o are registered, asserted the cycle after the offending request, for exactly one cycle.
- Pointer arithmetic: explicit wrap, not modulo-2^PtrW.
  - inc(p) = (p == Depth-1) ? 0 : p+1.
  - dec(p) = (p == 0) ? Depth-1 : p-1.
- Update priority each cycle: flush_i, then restore_i, then push_i/pop_i. ckpt_i is independent of push/pop.
- flush_i:
  - tp_q=0, cnt_q=0, snapshot cleared to 0.
  - mem contents retained but unobservable.
  - push, pop, ckpt and restore in the same cycle are ignored; no flags.
- restore_i (no flush):
  - tp_q=snap_tp_q, cnt_q=snap_cnt_q, mem[snap_tp_q]=snap_top_q.
  - Writing the top entry back repairs an entry clobbered by a later push.
  - Push/pop in the same cycle are ignored.
  - Restore with no checkpoint since reset or flush yields an empty stack.
- push_i only:
  - tp_q=inc(tp_q), mem[inc(tp_q)]=push_addr_i, cnt_q=min(cnt_q+1, Depth).
  - If cnt_q==Depth beforehand, the oldest entry is overwritten and overflow_o pulses.
- pop_i only:
  - If cnt_q>0: tp_q=dec(tp_q), cnt_q=cnt_q-1.
  - If cnt_q==0: no state change; underflow_o pulses.
- push_i and pop_i together (replace):
  - mem[tp_q]=push_addr_i, tp_q unchanged.
  - cnt_q=max(cnt_q, 1); an empty stack becomes count 1.
  - No flags.
- ckpt_i:
  - Captures the pre-update state of the same cycle: snap_tp_q=tp_q, snap_cnt_q=cnt_q, snap_top_q=mem[tp_q].
  - Ignored when flush_i or restore_i is asserted.
  - A new checkpoint overwrites the previous one; single level only.
- Elaboration: Depth<2 is a fatal assertion.

Test Plan:
- Reset then idle: after rst_i is released, top_valid_o=0, top_addr_o=0, count_o=0, no flag pulses.
- Depth=3: push 0x100, 0x200, 0x300, 0x400 -> count_o saturates at 3; overflow_o pulses only after the 4th push; pops return 0x400, 0x300, 0x200; a 4th pop raises underflow_o with count_o staying 0.
- Replace: push 0x10, then push+pop 0x20 in the same cycle -> count_o=1, top_addr_o=0x20; push+pop on an empty stack -> count_o=1.
- Checkpoint repair (Depth=2):
  - Stimulus: push 0xA, push 0xB, ckpt, pop, push 0xC (overwrites 0xB's slot), restore.
  - Response: count_o=2, top_addr_o=0xB; a following pop gives top 0xA.
- Priority: flush+restore+push in one cycle -> empty, snapshot cleared; a later restore -> still empty.
- Non-power-of-two wrap: Depth=5, 12 random push/pop sequences compared against a reference model, including the tp wrap from 4 to 0 and 0 to 4; asynchronous reset asserted mid-sequence -> outputs zero within the same cycle.

Source files
------------

// File: rtl/ras_ckpt.sv
// ras_ckpt: return-address stack for the frontend predictor.
//   Circular storage of Depth entries. Depth must be 2 or more and need not be a power of two.
//   When the stack is full, a push overwrites the oldest entry.
//   A push and a pop in the same cycle replace the top entry (coroutine call).
//   A single-level snapshot holds the pointer, the count and the top entry.
//   Restoring the snapshot repairs the stack after a mispredict.
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        asynchronous reset, active-high
//   flush_i      empty the stack and clear the snapshot
//   push_i       push push_addr_i (call)
//   pop_i        pop the top entry (return)
//   push_addr_i  return address to push
//   ckpt_i       capture a snapshot of the current state
//   restore_i    restore state from the snapshot
//   top_valid_o  stack is non-empty
//   top_addr_o   top entry, 0 when empty
//   count_o      occupancy, 0..Depth
//   overflow_o   one-cycle pulse: a push overwrote the oldest entry
//   underflow_o  one-cycle pulse: a pop was attempted on an empty stack
module ras_ckpt #(
  parameter  int Depth = 2,
  parameter  int VLEN  = 64,
  localparam int PtrW  = $clog2(Depth),
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] push_addr_i,
  input  logic            ckpt_i,
  input  logic            restore_i,
  output logic            top_valid_o,
  output logic [VLEN-1:0] top_addr_o,
  output logic [CntW-1:0] count_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  if (Depth < 2) begin : g_depth_check
    $fatal(1, "ras_ckpt: Depth must be 2 or more");
  end

  localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  // Explicit wrap: the pointer range is 0..Depth-1, not 0..2^PtrW-1.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
    return (p == '0) ? LastIdx : p - PtrW'(1);
  endfunction

  logic [VLEN-1:0] mem [Depth];
  logic [PtrW-1:0] tp_q, tp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] snap_tp_q;
  logic [CntW-1:0] snap_cnt_q;
  logic [VLEN-1:0] snap_top_q;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            wr_en;
  logic [PtrW-1:0] wr_idx;
  logic [VLEN-1:0] wr_data;
  logic            snap_ld;
  logic            snap_clr;
  logic [VLEN-1:0] top_entry;

  assign top_entry = mem[tp_q];

  always_comb begin
    tp_d     = tp_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_idx   = tp_q;
    wr_data  = push_addr_i;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    snap_ld  = 1'b0;
    snap_clr = 1'b0;
    if (flush_i) begin
      tp_d     = '0;
      cnt_d    = '0;
      snap_clr = 1'b1;
    end else if (restore_i) begin
      // The saved top entry is written back because a push after the
      // checkpoint may have reused that slot.
      tp_d    = snap_tp_q;
      cnt_d   = snap_cnt_q;
      wr_en   = 1'b1;
      wr_idx  = snap_tp_q;
      wr_data = snap_top_q;
    end else begin
      if (push_i && pop_i) begin
        wr_en = 1'b1;
        if (cnt_q == '0) cnt_d = CntW'(1);
      end else if (push_i) begin
        tp_d   = ptr_inc(tp_q);
        wr_en  = 1'b1;
        wr_idx = ptr_inc(tp_q);
        if (cnt_q == FullCnt) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + CntW'(1);
      end else if (pop_i) begin
        if (cnt_q != '0) begin
          tp_d  = ptr_dec(tp_q);
          cnt_d = cnt_q - CntW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      // The snapshot takes the state as it was before this cycle's push or pop.
      snap_ld = ckpt_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tp_q       <= '0;
      cnt_q      <= '0;
      snap_tp_q  <= '0;
      snap_cnt_q <= '0;
      snap_top_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (snap_clr) begin
        snap_tp_q  <= '0;
        snap_cnt_q <= '0;
        snap_top_q <= '0;
      end else if (snap_ld) begin
        snap_tp_q  <= tp_q;
        snap_cnt_q <= cnt_q;
        snap_top_q <= top_entry;
      end
    end
  end

  assign top_valid_o = (cnt_q != '0);
  assign top_addr_o  = top_valid_o ? top_entry : '0;
  assign count_o     = cnt_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt. Three instances (Depth 3, 2, 5) share one stimulus
// stream and are each compared every cycle against a circular-buffer model.
module tb_ras_ckpt;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0, push = 1'b0, pop = 1'b0, ckpt = 1'b0, restore = 1'b0;
  logic [63:0] addr = '0;

  logic        tv  [NI];
  logic [63:0] ta  [NI];
  logic        ovf [NI];
  logic        unf [NI];
  logic [1:0]  c0, c1;
  logic [2:0]  c2;
  int          ca  [NI];

  int compared = 0;
  int failed   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  ras_ckpt #(.Depth(3), .VLEN(64)) u_d3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
    .push_addr_i(addr), .ckpt_i(ckpt), .restore_i(restore),
    .top_valid_o(tv[0]), .top_addr_o(ta[0]), .count_o(c0),
    .overflow_o(ovf[0]), .underflow_o(unf[0]));

  ras_ckpt #(.Depth(2), .VLEN(64)) u_d2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
    .push_addr_i(addr), .ckpt_i(ckpt), .restore_i(restore),
    .top_valid_o(tv[1]), .top_addr_o(ta[1]), .count_o(c1),
    .overflow_o(ovf[1]), .underflow_o(unf[1]));

  ras_ckpt #(.Depth(5), .VLEN(64)) u_d5 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push), .pop_i(pop),
    .push_addr_i(addr), .ckpt_i(ckpt), .restore_i(restore),
    .top_valid_o(tv[2]), .top_addr_o(ta[2]), .count_o(c2),
    .overflow_o(ovf[2]), .underflow_o(unf[2]));

  always_comb begin
    ca[0] = int'(c0);
    ca[1] = int'(c1);
    ca[2] = int'(c2);
  end

  function automatic int dep(input int i);
    return (i == 0) ? 3 : (i == 1) ? 2 : 5;
  endfunction

  // Reference model: circular array of slots with a top index and a count.
  logic [63:0] mm   [NI][5];
  int          mtp  [NI];
  int          mcnt [NI];
  int          stp  [NI];
  int          scnt [NI];
  logic [63:0] stop [NI];
  bit          eovf [NI];
  bit          eunf [NI];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      int          d, otp, ocnt;
      logic [63:0] otop;
      d = dep(i);
      eovf[i] = 1'b0;
      eunf[i] = 1'b0;
      if (rst) begin
        for (int k = 0; k < 5; k++) mm[i][k] = '0;
        mtp[i] = 0; mcnt[i] = 0; stp[i] = 0; scnt[i] = 0; stop[i] = '0;
      end else if (flush) begin
        mtp[i] = 0; mcnt[i] = 0; stp[i] = 0; scnt[i] = 0; stop[i] = '0;
      end else if (restore) begin
        mtp[i] = stp[i];
        mcnt[i] = scnt[i];
        mm[i][stp[i]] = stop[i];
      end else begin
        otp = mtp[i]; ocnt = mcnt[i]; otop = mm[i][otp];
        if (push && pop) begin
          mm[i][mtp[i]] = addr;
          if (mcnt[i] < 1) mcnt[i] = 1;
        end else if (push) begin
          mtp[i] = (mtp[i] + 1) % d;
          mm[i][mtp[i]] = addr;
          if (ocnt == d) eovf[i] = 1'b1;
          else mcnt[i] = ocnt + 1;
        end else if (pop) begin
          if (ocnt > 0) begin
            mtp[i] = (mtp[i] + d - 1) % d;
            mcnt[i] = ocnt - 1;
          end else begin
            eunf[i] = 1'b1;
          end
        end
        if (ckpt) begin
          stp[i] = otp; scnt[i] = ocnt; stop[i] = otop;
        end
      end
    end
  end

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[d%0d] got %h expected %h at %0t", name, dep(inst), act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check("valid", i, 64'(tv[i]), 64'(mcnt[i] != 0));
        check("addr", i, ta[i], (mcnt[i] != 0) ? mm[i][mtp[i]] : 64'h0);
        check("count", i, 64'(ca[i]), 64'(mcnt[i]));
        check("overflow", i, 64'(ovf[i]), 64'(eovf[i]));
        check("underflow", i, 64'(unf[i]), 64'(eunf[i]));
      end
    end
  end

  task automatic cyc(input bit f, input bit pu, input bit po, input logic [63:0] a,
                     input bit ck, input bit rs);
    @(negedge clk);
    flush = f; push = pu; pop = po; addr = a; ckpt = ck; restore = rs;
    @(posedge clk);
    #1;
    flush = 0; push = 0; pop = 0; addr = '0; ckpt = 0; restore = 0;
  endtask

  task automatic mid_reset();
    cyc(0, 1, 0, 64'hBEEF, 0, 0);
    check("pre_rst_valid", 2, 64'(tv[2]), 64'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst_valid", i, 64'(tv[i]), 64'h0);
      check("rst_addr", i, ta[i], 64'h0);
      check("rst_count", i, 64'(ca[i]), 64'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    check("idle_valid", 0, 64'(tv[0]), 64'h0);
    check("idle_addr", 0, ta[0], 64'h0);
    check("idle_count", 0, 64'(ca[0]), 64'h0);
    check("idle_ovf", 0, 64'(ovf[0]), 64'h0);

    // Depth 3 saturation, overflow and underflow.
    cyc(0, 1, 0, 64'h100, 0, 0);
    cyc(0, 1, 0, 64'h200, 0, 0);
    cyc(0, 1, 0, 64'h300, 0, 0);
    check("sat_count3", 0, 64'(ca[0]), 64'd3);
    check("sat_noovf", 0, 64'(ovf[0]), 64'h0);
    cyc(0, 1, 0, 64'h400, 0, 0);
    check("sat_count4", 0, 64'(ca[0]), 64'd3);
    check("sat_ovf", 0, 64'(ovf[0]), 64'h1);
    check("sat_top", 0, ta[0], 64'h400);
    cyc(0, 0, 1, 64'h0, 0, 0);
    check("ovf_cleared", 0, 64'(ovf[0]), 64'h0);
    check("pop1_top", 0, ta[0], 64'h300);
    cyc(0, 0, 1, 64'h0, 0, 0);
    check("pop2_top", 0, ta[0], 64'h200);
    cyc(0, 0, 1, 64'h0, 0, 0);
    check("pop3_count", 0, 64'(ca[0]), 64'd0);
    check("pop3_addr", 0, ta[0], 64'h0);
    cyc(0, 0, 1, 64'h0, 0, 0);
    check("pop4_unf", 0, 64'(unf[0]), 64'h1);
    check("pop4_count", 0, 64'(ca[0]), 64'd0);

    // Replace.
    cyc(0, 1, 0, 64'h10, 0, 0);
    cyc(0, 1, 1, 64'h20, 0, 0);
    check("repl_count", 0, 64'(ca[0]), 64'd1);
    check("repl_top", 0, ta[0], 64'h20);
    cyc(1, 0, 0, 64'h0, 0, 0);
    cyc(0, 1, 1, 64'h30, 0, 0);
    check("repl_empty_count", 0, 64'(ca[0]), 64'd1);
    check("repl_empty_top", 0, ta[0], 64'h30);

    // Checkpoint repair, Depth 2.
    cyc(1, 0, 0, 64'h0, 0, 0);
    cyc(0, 1, 0, 64'hA, 0, 0);
    cyc(0, 1, 0, 64'hB, 0, 0);
    cyc(0, 0, 0, 64'h0, 1, 0);
    cyc(0, 0, 1, 64'h0, 0, 0);
    cyc(0, 1, 0, 64'hC, 0, 0);
    check("clobber_top", 1, ta[1], 64'hC);
    cyc(0, 0, 0, 64'h0, 0, 1);
    check("restore_count", 1, 64'(ca[1]), 64'd2);
    check("restore_top", 1, ta[1], 64'hB);
    cyc(0, 0, 1, 64'h0, 0, 0);
    check("restore_pop_top", 1, ta[1], 64'hA);

    // Priority: flush beats restore and push, and clears the snapshot.
    cyc(0, 1, 0, 64'h55, 0, 0);
    cyc(0, 0, 0, 64'h0, 1, 0);
    cyc(1, 1, 0, 64'h66, 0, 1);
    check("prio_count", 2, 64'(ca[2]), 64'd0);
    cyc(0, 0, 0, 64'h0, 0, 1);
    check("prio_restore_count", 2, 64'(ca[2]), 64'd0);
    check("prio_restore_valid", 2, 64'(tv[2]), 64'h0);

    // Random sequences against the model.
    for (int s = 0; s < 12; s++) begin
      for (int k = 0; k < 25; k++) begin
        bit pu, po, ck, rs, f;
        pu = ($urandom_range(0, 99) < 55);
        po = ($urandom_range(0, 99) < 40);
        ck = ($urandom_range(0, 99) < 20);
        rs = ($urandom_range(0, 99) < 8);
        f  = ($urandom_range(0, 99) < 3);
        cyc(f, pu, po, 64'($urandom), ck, rs);
        if (s == 6 && k == 12) mid_reset();
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
